// File: rtl/cam_link_seq_pkg.sv
// Shared types and clk_100-derived default timings for the camera link sequencer.
package cam_link_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PWR_OFF  = 3'd1,
    ST_PWR_ON   = 3'd2,
    ST_CFG      = 3'd3,
    ST_WAIT_FRM = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAULT    = 3'd6
  } cam_seq_state_t;

  localparam int CLK_HZ            = 100_000_000;
  localparam int T_OFF_DEF         = CLK_HZ / 100_000;  // 10 us off time
  localparam int T_ON_DEF          = CLK_HZ / 1_000;    // 1 ms power settle
  localparam int CFG_TIMEOUT_DEF   = CLK_HZ / 10;       // 100 ms for sensor config
  localparam int FRAME_TIMEOUT_DEF = CLK_HZ / 5;        // 200 ms between frames
  localparam int MAX_RETRY_DEF     = 3;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cam_link_seq.sv
// Camera link bring-up/supervision sequencer: power cycle, I2C config, CSI release,
// frame watchdog with bounded retries and a sticky fault.
module cam_link_seq
  import cam_link_seq_pkg::*;
#(
  parameter int T_OFF         = T_OFF_DEF,
  parameter int T_ON          = T_ON_DEF,
  parameter int CFG_TIMEOUT   = CFG_TIMEOUT_DEF,
  parameter int FRAME_TIMEOUT = FRAME_TIMEOUT_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        enable,
  input  logic        cfg_done,
  input  logic        cfg_err,
  input  logic        frame_sof,
  output logic        cam_en,
  output logic        i2c_areset_n,
  output logic        csi_reset,
  output logic        link_up,
  output logic        fault,
  output logic [3:0]  retry_cnt,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state_o
);

  localparam int TMAX = max4(T_OFF, T_ON, CFG_TIMEOUT, FRAME_TIMEOUT);
  localparam int TW   = $clog2(TMAX + 1);

  cam_seq_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     retry_q, retry_d;
  logic [15:0]    frame_q, frame_d;
  logic           expired;
  logic           restart;

  assign expired = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = expired ? '0 : timer_q - TW'(1);
    retry_d = retry_q;
    frame_d = frame_q;
    restart = 1'b0;
    if (state_q != ST_IDLE && !enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (enable) begin
          state_d = ST_PWR_OFF;
          timer_d = TW'(T_OFF - 1);
          retry_d = '0;
        end
        ST_PWR_OFF: if (expired) begin
          state_d = ST_PWR_ON;
          timer_d = TW'(T_ON - 1);
        end
        ST_PWR_ON: if (expired) begin
          state_d = ST_CFG;
          timer_d = TW'(CFG_TIMEOUT - 1);
        end
        ST_CFG: begin
          // A bus error invalidates a simultaneous done.
          if (cfg_err) begin
            restart = 1'b1;
          end else if (cfg_done) begin
            state_d = ST_WAIT_FRM;
            timer_d = TW'(FRAME_TIMEOUT - 1);
          end else if (expired) begin
            restart = 1'b1;
          end
        end
        ST_WAIT_FRM: begin
          if (frame_sof) begin
            state_d = ST_RUN;
            timer_d = TW'(FRAME_TIMEOUT - 1);
            retry_d = '0;
            frame_d = 16'd1;
          end else if (expired) begin
            restart = 1'b1;
          end
        end
        ST_RUN: begin
          if (frame_sof) begin
            timer_d = TW'(FRAME_TIMEOUT - 1);
            frame_d = frame_q + 16'd1;
          end else if (expired) begin
            restart = 1'b1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
    if (restart) begin
      if (retry_q == 4'(MAX_RETRY)) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_PWR_OFF;
        timer_d = TW'(T_OFF - 1);
        retry_d = retry_q + 4'd1;
      end
    end
  end

  // Outputs decode the current state register, so they follow it by one cycle.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      frame_q      <= '0;
      cam_en       <= 1'b0;
      i2c_areset_n <= 1'b0;
      csi_reset    <= 1'b1;
      link_up      <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      frame_q      <= frame_d;
      cam_en       <= (state_q == ST_PWR_ON) || (state_q == ST_CFG) ||
                      (state_q == ST_WAIT_FRM) || (state_q == ST_RUN);
      i2c_areset_n <= (state_q == ST_CFG) || (state_q == ST_WAIT_FRM) ||
                      (state_q == ST_RUN);
      csi_reset    <= !((state_q == ST_WAIT_FRM) || (state_q == ST_RUN));
      link_up      <= (state_q == ST_RUN);
      fault        <= (state_q == ST_FAULT);
    end
  end

  assign state_o   = state_q;
  assign retry_cnt = retry_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_cam_link_seq.sv
// Directed bench for cam_link_seq with shortened timings (T_OFF=4, T_ON=8, CFG=20, FRAME=50, retry=2).
module tb_cam_link_seq;

  logic        clk;
  logic        areset_n;
  logic        enable;
  logic        cfg_done;
  logic        cfg_err;
  logic        frame_sof;
  logic        cam_en;
  logic        i2c_areset_n;
  logic        csi_reset;
  logic        link_up;
  logic        fault;
  logic [3:0]  retry_cnt;
  logic [15:0] frame_cnt;
  logic [2:0]  state_o;

  int vectors;
  int miscompares;

  localparam logic [2:0] S_IDLE = 3'd0, S_OFF = 3'd1, S_ON = 3'd2, S_CFG = 3'd3,
                         S_WAIT = 3'd4, S_RUN = 3'd5, S_FAULT = 3'd6;

  cam_link_seq #(
    .T_OFF(4), .T_ON(8), .CFG_TIMEOUT(20), .FRAME_TIMEOUT(50), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .areset_n(areset_n), .enable(enable), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .frame_sof(frame_sof), .cam_en(cam_en),
    .i2c_areset_n(i2c_areset_n), .csi_reset(csi_reset), .link_up(link_up),
    .fault(fault), .retry_cnt(retry_cnt), .frame_cnt(frame_cnt), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n;
    n = 0;
    while (state_o !== s && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, {29'd0, state_o}, {29'd0, s});
  endtask

  task automatic pulse_sof_at(input int n);
    tick(n - 1);
    frame_sof = 1'b1;
    tick(1);
    frame_sof = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cam_en"}, {31'd0, cam_en}, 32'd0);
    chk({tag, "_i2c_rst_n"}, {31'd0, i2c_areset_n}, 32'd0);
    chk({tag, "_csi_reset"}, {31'd0, csi_reset}, 32'd1);
    chk({tag, "_link_up"}, {31'd0, link_up}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    areset_n = 1'b0;
    enable = 1'b0;
    cfg_done = 1'b0;
    cfg_err = 1'b0;
    frame_sof = 1'b0;
    tick(3);
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk_reset_outs("rst");
    chk("rst_retry", {28'd0, retry_cnt}, 32'd0);
    chk("rst_frame", {16'd0, frame_cnt}, 32'd0);

    // 1. Happy path with exact dwell times.
    areset_n = 1'b1;
    enable = 1'b1;
    tick(1);
    chk("hp_pwr_off", {29'd0, state_o}, {29'd0, S_OFF});
    tick(4);
    chk("hp_pwr_on", {29'd0, state_o}, {29'd0, S_ON});
    chk("hp_cam_en_lag", {31'd0, cam_en}, 32'd0);
    tick(1);
    chk("hp_cam_en", {31'd0, cam_en}, 32'd1);
    chk("hp_i2c_held", {31'd0, i2c_areset_n}, 32'd0);
    tick(7);
    chk("hp_cfg", {29'd0, state_o}, {29'd0, S_CFG});
    chk("hp_i2c_lag", {31'd0, i2c_areset_n}, 32'd0);
    tick(1);
    chk("hp_i2c_rel", {31'd0, i2c_areset_n}, 32'd1);
    chk("hp_csi_held", {31'd0, csi_reset}, 32'd1);
    tick(3);
    cfg_done = 1'b1;
    tick(1);
    cfg_done = 1'b0;
    chk("hp_wait_frm", {29'd0, state_o}, {29'd0, S_WAIT});
    tick(1);
    chk("hp_csi_rel", {31'd0, csi_reset}, 32'd0);
    chk("hp_no_link", {31'd0, link_up}, 32'd0);
    pulse_sof_at(9);
    chk("hp_run", {29'd0, state_o}, {29'd0, S_RUN});
    chk("hp_frame1", {16'd0, frame_cnt}, 32'd1);
    tick(1);
    chk("hp_link_up", {31'd0, link_up}, 32'd1);
    pulse_sof_at(40);
    chk("hp_frame2", {16'd0, frame_cnt}, 32'd2);
    pulse_sof_at(40);
    chk("hp_frame3", {16'd0, frame_cnt}, 32'd3);
    chk("hp_retry0", {28'd0, retry_cnt}, 32'd0);

    // 4. Stall after frame 3: watchdog fires 50 cycles after the last sof.
    tick(49);
    chk("st_still_run", {29'd0, state_o}, {29'd0, S_RUN});
    tick(1);
    chk("st_restart", {29'd0, state_o}, {29'd0, S_OFF});
    chk("st_retry1", {28'd0, retry_cnt}, 32'd1);
    tick(1);
    chk("st_link_down", {31'd0, link_up}, 32'd0);
    chk("st_csi_reset", {31'd0, csi_reset}, 32'd1);
    chk("st_i2c_reset", {31'd0, i2c_areset_n}, 32'd0);
    wait_state("st_cfg", S_CFG, 30);
    cfg_done = 1'b1;
    tick(1);
    cfg_done = 1'b0;
    chk("st_wait", {29'd0, state_o}, {29'd0, S_WAIT});
    pulse_sof_at(3);
    chk("st_run", {29'd0, state_o}, {29'd0, S_RUN});
    chk("st_retry_clr", {28'd0, retry_cnt}, 32'd0);
    chk("st_frame1", {16'd0, frame_cnt}, 32'd1);

    // 5. enable dropped mid-RUN and mid-CFG.
    pulse_sof_at(10);
    chk("en_frame2", {16'd0, frame_cnt}, 32'd2);
    cfg_err = 1'b1;  // ignored in RUN
    tick(5);
    cfg_err = 1'b0;
    chk("run_cfg_err_ign", {29'd0, state_o}, {29'd0, S_RUN});
    enable = 1'b0;
    tick(1);
    chk("en_run_idle", {29'd0, state_o}, {29'd0, S_IDLE});
    tick(1);
    chk_reset_outs("en_run");
    chk("en_frame_kept", {16'd0, frame_cnt}, 32'd2);
    enable = 1'b1;
    wait_state("en_cfg", S_CFG, 30);
    tick(3);
    enable = 1'b0;
    tick(1);
    chk("en_cfg_idle", {29'd0, state_o}, {29'd0, S_IDLE});
    tick(1);
    chk_reset_outs("en_cfg");
    chk("en_frame_kept2", {16'd0, frame_cnt}, 32'd2);

    // 3. cfg_err and cfg_done together: error wins.
    enable = 1'b1;
    wait_state("ed_cfg", S_CFG, 30);
    cfg_err = 1'b1;
    cfg_done = 1'b1;
    tick(1);
    cfg_err = 1'b0;
    cfg_done = 1'b0;
    chk("ed_restart", {29'd0, state_o}, {29'd0, S_OFF});
    chk("ed_retry1", {28'd0, retry_cnt}, 32'd1);

    // 2. Config timeout until FAULT.
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(1);
    chk("to_retry_clr", {28'd0, retry_cnt}, 32'd0);
    wait_state("to_cfg0", S_CFG, 30);
    tick(19);
    chk("to_cfg_dwell", {29'd0, state_o}, {29'd0, S_CFG});
    tick(1);
    chk("to_restart1", {29'd0, state_o}, {29'd0, S_OFF});
    chk("to_retry1", {28'd0, retry_cnt}, 32'd1);
    wait_state("to_cfg1", S_CFG, 30);
    tick(20);
    chk("to_retry2", {28'd0, retry_cnt}, 32'd2);
    wait_state("to_cfg2", S_CFG, 30);
    tick(20);
    chk("to_fault", {29'd0, state_o}, {29'd0, S_FAULT});
    chk("to_retry_hold", {28'd0, retry_cnt}, 32'd2);
    tick(1);
    chk("to_fault_flag", {31'd0, fault}, 32'd1);
    chk("to_fault_cam", {31'd0, cam_en}, 32'd0);
    chk("to_fault_csi", {31'd0, csi_reset}, 32'd1);
    tick(10);
    chk("to_fault_sticky", {31'd0, fault}, 32'd1);
    enable = 1'b0;
    tick(1);
    chk("to_idle", {29'd0, state_o}, {29'd0, S_IDLE});
    tick(1);
    chk("to_fault_clr", {31'd0, fault}, 32'd0);

    // 6. Asynchronous reset pulse mid-RUN.
    enable = 1'b1;
    wait_state("ar_cfg", S_CFG, 30);
    cfg_done = 1'b1;
    tick(1);
    cfg_done = 1'b0;
    pulse_sof_at(2);
    tick(2);
    chk("ar_link_up", {31'd0, link_up}, 32'd1);
    areset_n = 1'b0;
    #1;
    chk("ar_state", {29'd0, state_o}, 32'd0);
    chk_reset_outs("ar_async");
    chk("ar_frame", {16'd0, frame_cnt}, 32'd0);
    tick(1);
    chk("ar_held", {31'd0, link_up}, 32'd0);
    areset_n = 1'b1;
    tick(1);
    chk("ar_restart", {29'd0, state_o}, {29'd0, S_OFF});
    frame_sof = 1'b1;  // ignored outside WAIT_FRM/RUN
    tick(1);
    frame_sof = 1'b0;
    chk("ar_sof_ign", {16'd0, frame_cnt}, 32'd0);
    chk("ar_sof_state", {29'd0, state_o}, {29'd0, S_OFF});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
